// File: rtl/reg_write_arbiter_if.sv
// Write-request bus between the compute requesters and the register-bank write arbiter.
// Requesters drive the i_* side; the arbiter drives grants and the bank write port.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int WORD_WIDTH = 32
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ*WORD_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_gnt;
    logic [NUM_REGS-1:0]           o_wr_en;
    logic [WORD_WIDTH-1:0]         o_wr_data;
    logic                          o_err;
    logic                          o_busy;

    modport master (
        output i_req, i_lock, i_addr, i_data,
        input  o_gnt, o_wr_en, o_wr_data, o_err, o_busy
    );

    modport slave (
        input  i_req, i_lock, i_addr, i_data,
        output o_gnt, o_wr_en, o_wr_data, o_err, o_busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a register bank, with locked bursts capped at MAX_BURST beats.
// All outputs are registered; the grant cycle is also the bank's clk_en cycle.
//
//   state | meaning
//   IDLE  | no beat granted last cycle
//   GRANT | single unlocked beat granted last cycle
//   BURST | locked owner granted last cycle; count = beats issued so far
module reg_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int WORD_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    reg_write_arbiter_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int PTR_W      = $clog2(NUM_REQ);
    localparam int CNT_W      = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0]            state, state_d;
    logic [PTR_W-1:0]      rr, rr_d;
    logic [PTR_W-1:0]      owner, owner_d;
    logic [PTR_W-1:0]      win, sel;
    logic [CNT_W-1:0]      count, count_d;
    logic                  found, owner_ok, grant;
    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [WORD_WIDTH-1:0] data_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [NUM_REQ-1:0]    gnt_d;
    logic [NUM_REGS-1:0]   wr_en_d;
    logic [WORD_WIDTH-1:0] wr_data_d;
    logic                  err_d;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign addr_a[r] = bus.i_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[r] = bus.i_data[r*WORD_WIDTH +: WORD_WIDTH];
    end

    always_comb begin
        found = 1'b0;
        win   = rr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.i_req[wrap_inc(rr, k)]) begin
                found = 1'b1;
                win   = wrap_inc(rr, k);
            end
        end
    end

    assign owner_ok = (state == BURST) && bus.i_req[owner] && bus.i_lock[owner]
                      && (int'(count) < MAX_BURST);

    // A burst that ends for any reason falls straight into a fresh arbitration,
    // so the pointer (already past the owner) hands the bus to someone else.
    always_comb begin
        state_d = IDLE;
        rr_d    = rr;
        owner_d = owner;
        count_d = '0;
        grant   = 1'b0;
        sel     = owner;
        if (owner_ok) begin
            grant   = 1'b1;
            state_d = BURST;
            count_d = count + 1'b1;
        end else if (found) begin
            grant   = 1'b1;
            sel     = win;
            owner_d = win;
            rr_d    = wrap_inc(win, 1);
            if (bus.i_lock[win]) begin
                state_d = BURST;
                count_d = CNT_W'(1);
            end else begin
                state_d = GRANT;
            end
        end
    end

    assign sel_addr = addr_a[sel];

    always_comb begin
        gnt_d     = '0;
        wr_en_d   = '0;
        err_d     = 1'b0;
        wr_data_d = bus.o_wr_data;
        if (grant) begin
            gnt_d[sel] = 1'b1;
            wr_data_d  = data_a[sel];
            if (int'(sel_addr) < NUM_REGS) wr_en_d[sel_addr] = 1'b1;
            else                           err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr            <= '0;
            owner         <= '0;
            count         <= '0;
            bus.o_gnt     <= '0;
            bus.o_wr_en   <= '0;
            bus.o_wr_data <= '0;
            bus.o_err     <= 1'b0;
            bus.o_busy    <= 1'b0;
        end else begin
            state         <= state_d;
            rr            <= rr_d;
            owner         <= owner_d;
            count         <= count_d;
            bus.o_gnt     <= gnt_d;
            bus.o_wr_en   <= wr_en_d;
            bus.o_wr_data <= wr_data_d;
            bus.o_err     <= err_d;
            bus.o_busy    <= (state_d == BURST);
        end
    end

    a_gnt_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bus.o_gnt));
    a_wr_en_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bus.o_wr_en));
    a_gnt_had_req:  assert property (@(posedge clk) disable iff (!reset_n)
                                     ~|(bus.o_gnt & ~$past(bus.i_req)));
    a_burst_cap:    assert property (@(posedge clk) disable iff (!reset_n) int'(count) <= MAX_BURST);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: two arbiters (8-reg and 6-reg banks) share one set of requester streams.
// Directed beats are queued per requester; hand-ordered expected grants are queued for the monitor.
module tb_reg_write_arbiter;
    localparam int NREQ = 4;

    typedef struct packed {
        logic        lock;
        logic [2:0]  addr;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [7:0]  wr_en8;
        logic [5:0]  wr_en6;
        logic [31:0] data;
        logic        err6;
        logic        busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   lock = '0;
    logic [11:0]  addr = '0;
    logic [127:0] data = '0;
    logic [31:0]  bank8 [8];
    logic [31:0]  bank6 [6];
    logic [31:0]  snap6 [6];
    beat_t        rq [NREQ][$];
    exp_t         exq [$];
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           sb_on = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(8), .WORD_WIDTH(32)) bus8 ();
    reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(6), .WORD_WIDTH(32)) bus6 ();

    assign bus8.i_req  = req;
    assign bus8.i_lock = lock;
    assign bus8.i_addr = addr;
    assign bus8.i_data = data;
    assign bus6.i_req  = req;
    assign bus6.i_lock = lock;
    assign bus6.i_addr = addr;
    assign bus6.i_data = data;

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .WORD_WIDTH(32), .MAX_BURST(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8));
    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .WORD_WIDTH(32), .MAX_BURST(4)) dut6 (
        .clk(clk), .reset_n(reset_n), .bus(bus6));

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (bus8.o_wr_en[i]) bank8[i] <= bus8.o_wr_data;
        for (int i = 0; i < 6; i++) if (bus6.o_wr_en[i]) bank6[i] <= bus6.o_wr_data;
    end

    function automatic logic [31:0] fd(input int a);
        return 32'h1111_1111 * (a + 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_beat(input int r, input logic lk, input logic [2:0] a, input logic [31:0] d);
        beat_t b;
        b.lock = lk;
        b.addr = a;
        b.data = d;
        rq[r].push_back(b);
    endtask

    task automatic expect_beat(input int r, input logic [2:0] a, input logic [31:0] d, input logic bsy);
        exp_t e;
        e.gnt    = 4'b0001 << r;
        e.wr_en8 = 8'b0000_0001 << a;
        e.wr_en6 = (a < 3'd6) ? 6'(8'b0000_0001 << a) : 6'b0;
        e.err6   = (a >= 3'd6);
        e.data   = d;
        e.busy   = bsy;
        exq.push_back(e);
    endtask

    task automatic refresh();
        for (int r = 0; r < NREQ; r++) begin
            if (rq[r].size() != 0) begin
                req[r]            = 1'b1;
                lock[r]           = rq[r][0].lock;
                addr[r*3 +: 3]    = rq[r][0].addr;
                data[r*32 +: 32]  = rq[r][0].data;
            end else begin
                req[r]  = 1'b0;
                lock[r] = 1'b0;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"},     {bus6.o_gnt, bus8.o_gnt}, 64'h0);
        chk({tag, "_wr_en"},   {bus6.o_wr_en, bus8.o_wr_en}, 64'h0);
        chk({tag, "_wr_data"}, {bus6.o_wr_data, bus8.o_wr_data}, 64'h0);
        chk({tag, "_err_busy"}, {bus6.o_err, bus6.o_busy, bus8.o_err, bus8.o_busy}, 64'h0);
    endtask

    task automatic drain(input string nm, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (exq.size() != 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_outstanding"}, 64'(exq.size()), 64'h0);
        exq.delete();
        chk({nm, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    endtask

    initial begin
        fork
            // requester driver: consume a beat on its grant, present the next head
            forever begin
                @(posedge clk);
                #1;
                for (int r = 0; r < NREQ; r++)
                    if (reset_n && bus8.o_gnt[r] && rq[r].size() != 0) rq[r].delete(0);
                refresh();
                @(negedge clk);
                #2;
                refresh();
            end
            // monitor
            forever begin
                @(negedge clk);
                if (reset_n && sb_on) begin
                    if (bus8.o_gnt != 4'b0) begin
                        if (exq.size() == 0) begin
                            chk("unexpected_grant", 64'(bus8.o_gnt), 64'h0);
                        end else begin
                            exp_t e;
                            e = exq.pop_front();
                            chk("gnt8", 64'(bus8.o_gnt), 64'(e.gnt));
                            chk("gnt6", 64'(bus6.o_gnt), 64'(e.gnt));
                            chk("wr_en8", 64'(bus8.o_wr_en), 64'(e.wr_en8));
                            chk("wr_en6", 64'(bus6.o_wr_en), 64'(e.wr_en6));
                            chk("wr_data8", 64'(bus8.o_wr_data), 64'(e.data));
                            chk("wr_data6", 64'(bus6.o_wr_data), 64'(e.data));
                            chk("err8", 64'(bus8.o_err), 64'h0);
                            chk("err6", 64'(bus6.o_err), 64'(e.err6));
                            chk("busy", {bus6.o_busy, bus8.o_busy}, {e.busy, e.busy});
                        end
                    end else begin
                        chk("idle_outputs", {bus6.o_gnt, bus6.o_wr_en, bus6.o_err,
                                             bus8.o_wr_en, bus8.o_err}, 64'h0);
                    end
                end
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                chk_reset("init_rst");
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);

                // fairness: every requester holds two unlocked beats
                for (int r = 0; r < NREQ; r++) begin
                    push_beat(r, 1'b0, 3'(r), fd(r));
                    push_beat(r, 1'b0, 3'(r + 4), fd(r + 4));
                end
                for (int k = 0; k < 8; k++)
                    expect_beat(k % 4, 3'((k < 4) ? (k % 4) : (k % 4) + 4), fd((k < 4) ? (k % 4) : (k % 4) + 4), 1'b0);
                drain("fair", 8);

                // write path: req2 -> reg 5
                @(negedge clk);
                push_beat(2, 1'b0, 3'd5, 32'hDEAD_BEEF);
                expect_beat(2, 3'd5, 32'hDEAD_BEEF, 1'b0);
                drain("wr", 1);
                chk("bank5_before", 64'(bank8[5]), 64'h6666_6666);
                @(negedge clk);
                #1;
                chk("bank8_5_after", 64'(bank8[5]), 64'hDEAD_BEEF);
                chk("bank6_5_after", 64'(bank6[5]), 64'hDEAD_BEEF);

                // bad address on the 6-register bank: req3 -> reg 7
                @(negedge clk);
                for (int i = 0; i < 6; i++) snap6[i] = bank6[i];
                push_beat(3, 1'b0, 3'd7, 32'h0BAD_CAFE);
                expect_beat(3, 3'd7, 32'h0BAD_CAFE, 1'b0);
                drain("badaddr", 1);
                @(negedge clk);
                #1;
                for (int i = 0; i < 6; i++) chk($sformatf("bank6_%0d_kept", i), 64'(bank6[i]), 64'(snap6[i]));
                chk("bank8_7", 64'(bank8[7]), 64'h0BAD_CAFE);

                // early burst exit: req0 locks for 2 beats then drops lock, req2 pending
                @(negedge clk);
                push_beat(0, 1'b1, 3'd1, 32'hE000_0000);
                push_beat(0, 1'b1, 3'd2, 32'hE000_0001);
                push_beat(0, 1'b0, 3'd3, 32'hE000_0002);
                push_beat(2, 1'b0, 3'd4, 32'hE000_0003);
                expect_beat(0, 3'd1, 32'hE000_0000, 1'b1);
                expect_beat(0, 3'd2, 32'hE000_0001, 1'b1);
                expect_beat(2, 3'd4, 32'hE000_0003, 1'b0);
                expect_beat(0, 3'd3, 32'hE000_0002, 1'b0);
                drain("early", 4);

                // burst cap: req1 locked for 5 beats, req0 and req3 pending
                @(negedge clk);
                push_beat(0, 1'b0, 3'd0, 32'hC000_0000);
                for (int k = 0; k < 5; k++) push_beat(1, 1'b1, 3'(k), 32'hB000_0000 + k);
                push_beat(3, 1'b0, 3'd6, 32'hC000_0003);
                for (int k = 0; k < 4; k++) expect_beat(1, 3'(k), 32'hB000_0000 + k, 1'b1);
                expect_beat(3, 3'd6, 32'hC000_0003, 1'b0);
                expect_beat(0, 3'd0, 32'hC000_0000, 1'b0);
                expect_beat(1, 3'd4, 32'hB000_0004, 1'b1);
                drain("cap", 7);

                // reset mid-burst with all four requesting
                @(negedge clk);
                sb_on = 1'b0;
                for (int k = 0; k < 4; k++) push_beat(0, 1'b1, 3'd0, 32'h5000_0000 + k);
                for (int r = 1; r < NREQ; r++) begin
                    push_beat(r, 1'b0, 3'(r), 32'h6000_0000 + r);
                    push_beat(r, 1'b0, 3'(r), 32'h6100_0000 + r);
                end
                begin
                    int w;
                    w = 0;
                    while (!bus8.o_busy && w < 20) begin
                        @(negedge clk);
                        w++;
                    end
                end
                chk("rst_burst_seen", 64'(bus8.o_busy), 64'h1);
                chk("rst_all_req", 64'(req), 64'hF);
                #1;
                reset_n = 1'b0;
                #1;
                chk_reset("mid_rst");
                @(negedge clk);
                for (int r = 0; r < NREQ; r++) rq[r].delete();
                for (int r = 0; r < NREQ; r++) begin
                    push_beat(r, 1'b0, 3'(r), 32'h7000_0000 + r);
                    expect_beat(r, 3'(r), 32'h7000_0000 + r, 1'b0);
                end
                @(negedge clk);
                #1;
                chk_reset("held_rst");
                @(negedge clk);
                reset_n = 1'b1;
                sb_on   = 1'b1;
                drain("post_rst", 4);
                repeat (2) @(negedge clk);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
